// File: rtl/snake_engine.sv
// snake_engine: grid snake game core; segments live in a circular buffer,
// collisions are resolved against an occupancy bitmap of the grid.
module snake_engine #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int MAX_LEN = 128,
  parameter int WRAP = 0,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           start,
  input  logic [1:0]                     direction,
  input  logic [XW-1:0]                  apple_x,
  input  logic [YW-1:0]                  apple_y,
  output logic [XW-1:0]                  head_x,
  output logic [YW-1:0]                  head_y,
  output logic [LW-1:0]                  snake_length,
  output logic                           apple_eaten,
  output logic                           dead,
  output logic [1:0]                     state,
  output logic [GRID_W-1:0][GRID_H-1:0]  RedPixels,
  output logic [GRID_W-1:0][GRID_H-1:0]  GrnPixels
);
  localparam int PW = $clog2(MAX_LEN);
  localparam logic [XW-1:0] X0 = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y0 = YW'(GRID_H / 2);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10} state_t;
  state_t cur, nxt;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [PW-1:0] hp, tp;
  logic [1:0] heading, dir_eff;
  logic [GRID_W-1:0][GRID_H-1:0] occ;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic off, at_apple, grow, on_tail, hit, fatal, step, reload;

  assign state = cur;
  assign dead = cur == DEAD;
  assign step = cur == RUN && enable;
  assign reload = cur == DEAD && start;

  // opposite headings share bit 1 and differ in bit 0
  always_comb begin
    dir_eff = (direction[1] == heading[1] && direction[0] != heading[0]) ? heading : direction;
    nx = dir_eff == 2'b00 ? head_x - XW'(1) : dir_eff == 2'b01 ? head_x + XW'(1) : head_x;
    ny = dir_eff == 2'b10 ? head_y - YW'(1) : dir_eff == 2'b11 ? head_y + YW'(1) : head_y;
    off = (dir_eff == 2'b00 && head_x == '0) || (dir_eff == 2'b01 && head_x == XW'(GRID_W - 1)) ||
          (dir_eff == 2'b10 && head_y == '0) || (dir_eff == 2'b11 && head_y == YW'(GRID_H - 1));
    at_apple = nx == apple_x && ny == apple_y;
    grow = at_apple && snake_length < LW'(MAX_LEN);
    on_tail = nx == seg_x[tp] && ny == seg_y[tp];
    hit = occ[nx][ny] && !(on_tail && !grow);
    fatal = (off && WRAP == 0) || hit;
    nxt = (cur == IDLE && start) ? RUN : (step && fatal) ? DEAD : reload ? IDLE : cur;
  end

  always_comb begin
    GrnPixels = '0;
    GrnPixels[head_x][head_y] = 1'b1;
    RedPixels = occ & ~GrnPixels;
    RedPixels[apple_x][apple_y] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= IDLE;
    else cur <= nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        seg_x[i] <= X0 - XW'(2 - i);
        seg_y[i] <= Y0;
      end
      tp <= '0;
      hp <= PW'(2);
      head_x <= X0;
      head_y <= Y0;
      heading <= 2'b01;
      snake_length <= LW'(3);
      apple_eaten <= 1'b0;
      occ <= '0;
      occ[X0][Y0] <= 1'b1;
      occ[X0 - XW'(1)][Y0] <= 1'b1;
      occ[X0 - XW'(2)][Y0] <= 1'b1;
    end else if (reload) begin
      for (int i = 0; i < 3; i++) begin
        seg_x[i] <= X0 - XW'(2 - i);
        seg_y[i] <= Y0;
      end
      tp <= '0;
      hp <= PW'(2);
      head_x <= X0;
      head_y <= Y0;
      heading <= 2'b01;
      snake_length <= LW'(3);
      apple_eaten <= 1'b0;
      occ <= '0;
      occ[X0][Y0] <= 1'b1;
      occ[X0 - XW'(1)][Y0] <= 1'b1;
      occ[X0 - XW'(2)][Y0] <= 1'b1;
    end else begin
      apple_eaten <= 1'b0;
      if (step && !fatal) begin
        seg_x[hp + PW'(1)] <= nx;
        seg_y[hp + PW'(1)] <= ny;
        hp <= hp + PW'(1);
        head_x <= nx;
        head_y <= ny;
        heading <= dir_eff;
        apple_eaten <= at_apple;
        if (grow) snake_length <= snake_length + LW'(1);
        else begin
          tp <= tp + PW'(1);
          occ[seg_x[tp]][seg_y[tp]] <= 1'b0;
        end
        // head set last so a head landing on the vacating tail stays occupied
        occ[nx][ny] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed scenarios plus randomized play against a queue-based model
module tb_snake_engine;
  logic clk = 1'b0;
  logic rst, enable, start;
  logic [1:0] direction;
  logic [3:0] apple_x, apple_y;
  logic [3:0] hx0, hy0, hx1, hy1;
  logic [7:0] len0;
  logic [2:0] len1;
  logic ate0, dead0, ate1, dead1;
  logic [1:0] st0, st1;
  logic [15:0][15:0] red0, grn0, red1, grn1;
  int vectors = 0, errors = 0;
  int mqx[$], mqy[$];
  int mhd, mst, mate;

  always #5 clk = ~clk;

  snake_engine #(.GRID_W(16), .GRID_H(16), .MAX_LEN(128), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .direction(direction),
    .apple_x(apple_x), .apple_y(apple_y), .head_x(hx0), .head_y(hy0), .snake_length(len0),
    .apple_eaten(ate0), .dead(dead0), .state(st0), .RedPixels(red0), .GrnPixels(grn0));

  snake_engine #(.GRID_W(16), .GRID_H(16), .MAX_LEN(4), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .direction(direction),
    .apple_x(apple_x), .apple_y(apple_y), .head_x(hx1), .head_y(hy1), .snake_length(len1),
    .apple_eaten(ate1), .dead(dead1), .state(st1), .RedPixels(red1), .GrnPixels(grn1));

  task automatic model_init();
    mqx = {6, 7, 8};
    mqy = {8, 8, 8};
    mhd = 1;
    mate = 0;
  endtask

  // model of the WRAP=0, MAX_LEN=128 instance; queue front is the tail
  task automatic model_step();
    int d, nx, ny;
    bit fatal, grow;
    mate = 0;
    if (mst == 0) begin
      if (start) mst = 1;
    end else if (mst == 2) begin
      if (start) begin
        mst = 0;
        model_init();
      end
    end else if (enable) begin
      d = direction;
      if ((d ^ mhd) == 1) d = mhd;
      nx = mqx[$] + (d == 1) - (d == 0);
      ny = mqy[$] + (d == 3) - (d == 2);
      fatal = nx < 0 || nx > 15 || ny < 0 || ny > 15;
      grow = nx == apple_x && ny == apple_y && mqx.size() < 128;
      for (int i = grow ? 0 : 1; i < mqx.size(); i++)
        if (mqx[i] == nx && mqy[i] == ny) fatal = 1;
      if (fatal) mst = 2;
      else begin
        mqx.push_back(nx);
        mqy.push_back(ny);
        if (!grow) begin
          void'(mqx.pop_front());
          void'(mqy.pop_front());
        end
        mate = nx == apple_x && ny == apple_y;
        mhd = d;
      end
    end
  endtask

  function automatic logic [15:0][15:0] exp_red();
    logic [15:0][15:0] r = '0;
    for (int i = 0; i < mqx.size() - 1; i++) r[mqx[i]][mqy[i]] = 1'b1;
    r[apple_x][apple_y] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0][15:0] exp_grn();
    logic [15:0][15:0] g = '0;
    g[mqx[$]][mqy[$]] = 1'b1;
    return g;
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; enable = 0; direction = 0; apple_x = 0; apple_y = 0;
    mst = 0;
    model_init();
    #2;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; enable = 0; direction = 0; apple_x = 0; apple_y = 0;
    mst = 0;
    model_init();
    #2;
    vectors++;
    if ({st0, hx0, hy0, len0, ate0, dead0} !== {2'd0, 4'd8, 4'd8, 8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_regs got %h want %h", {st0, hx0, hy0, len0, ate0, dead0}, {2'd0, 4'd8, 4'd8, 8'd3, 1'b0, 1'b0});
    end
    vectors++;
    if (red0 !== exp_red() || grn0 !== exp_grn()) begin
      errors++;
      $display("FAIL reset_pixels got red %h grn %h want red %h grn %h", red0, grn0, exp_red(), exp_grn());
    end
    @(negedge clk);
    rst = 0;
    enable = 1;
    for (int i = 0; i < 5; i++) begin
      direction = 2'($urandom);
      cyc();
    end
    enable = 0;
    vectors++;
    if ({st0, hx0, hy0, len0, grn0[8][8], red0[7][8], red0[6][8]} !== {2'd0, 4'd8, 4'd8, 8'd3, 3'b111}) begin
      errors++;
      $display("FAIL idle_ignores_enable got %h want %h", {st0, hx0, hy0, len0, grn0[8][8], red0[7][8], red0[6][8]}, {2'd0, 4'd8, 4'd8, 8'd3, 3'b111});
    end
  endtask

  task automatic test_move();
    do_reset();
    start = 1; cyc(); start = 0;
    direction = 1; enable = 1;
    repeat (3) cyc();
    enable = 0;
    vectors++;
    if ({st0, hx0, hy0, len0, red0[7][8], red0[9][8], red0[10][8]} !== {2'd1, 4'd11, 4'd8, 8'd3, 3'b011}) begin
      errors++;
      $display("FAIL move_right got %h want %h", {st0, hx0, hy0, len0, red0[7][8], red0[9][8], red0[10][8]}, {2'd1, 4'd11, 4'd8, 8'd3, 3'b011});
    end
    direction = 0; enable = 1; start = 1;
    cyc();
    enable = 0; start = 0;
    vectors++;
    if ({st0, hx0, hy0} !== {2'd1, 4'd12, 4'd8}) begin
      errors++;
      $display("FAIL reversal_rejected got %h want %h", {st0, hx0, hy0}, {2'd1, 4'd12, 4'd8});
    end
  endtask

  task automatic test_eat();
    do_reset();
    apple_x = 9; apple_y = 8;
    start = 1; cyc(); start = 0;
    direction = 1; enable = 1; cyc(); enable = 0;
    vectors++;
    if ({ate0, hx0, hy0, len0, red0[6][8]} !== {1'b1, 4'd9, 4'd8, 8'd4, 1'b1}) begin
      errors++;
      $display("FAIL eat_grow got %h want %h", {ate0, hx0, hy0, len0, red0[6][8]}, {1'b1, 4'd9, 4'd8, 8'd4, 1'b1});
    end
    cyc();
    vectors++;
    if (ate0 !== 1'b0) begin
      errors++;
      $display("FAIL eat_pulse_width got %b want 0", ate0);
    end
  endtask

  task automatic test_wall();
    do_reset();
    start = 1; cyc(); start = 0;
    direction = 1; enable = 1;
    repeat (7) cyc();
    vectors++;
    if ({dead0, hx0, hy0} !== {1'b0, 4'd15, 4'd8}) begin
      errors++;
      $display("FAIL wall_edge got %h want %h", {dead0, hx0, hy0}, {1'b0, 4'd15, 4'd8});
    end
    cyc();
    vectors++;
    if ({dead0, st0, hx0, hy0, len0, ate0} !== {1'b1, 2'd2, 4'd15, 4'd8, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL wall_fatal got %h want %h", {dead0, st0, hx0, hy0, len0, ate0}, {1'b1, 2'd2, 4'd15, 4'd8, 8'd3, 1'b0});
    end
    vectors++;
    if ({dead1, st1, hx1, hy1, len1} !== {1'b0, 2'd1, 4'd0, 4'd8, 3'd3}) begin
      errors++;
      $display("FAIL wrap_alive got %h want %h", {dead1, st1, hx1, hy1, len1}, {1'b0, 2'd1, 4'd0, 4'd8, 3'd3});
    end
    cyc();
    vectors++;
    if ({st0, hx0} !== {2'd2, 4'd15}) begin
      errors++;
      $display("FAIL dead_ignores_enable got %h want %h", {st0, hx0}, {2'd2, 4'd15});
    end
    start = 1; cyc(); start = 0; enable = 0;
    vectors++;
    if ({st0, hx0, hy0, len0, st1} !== {2'd0, 4'd8, 4'd8, 8'd3, 2'd1}) begin
      errors++;
      $display("FAIL start_priority got %h want %h", {st0, hx0, hy0, len0, st1}, {2'd0, 4'd8, 4'd8, 8'd3, 2'd1});
    end
  endtask

  task automatic test_self();
    do_reset();
    start = 1; cyc(); start = 0;
    enable = 1; direction = 1;
    apple_x = 9; apple_y = 8; cyc();
    apple_x = 10; cyc();
    apple_x = 0; apple_y = 0;
    direction = 2; cyc();
    direction = 0; cyc();
    direction = 3; cyc();
    enable = 0;
    vectors++;
    if ({st0, hx0, hy0, len0, red0[9][8], ate0} !== {2'd2, 4'd9, 4'd7, 8'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL self_hit got %h want %h", {st0, hx0, hy0, len0, red0[9][8], ate0}, {2'd2, 4'd9, 4'd7, 8'd5, 1'b1, 1'b0});
    end
    start = 1; cyc(); start = 0;
    vectors++;
    if ({st0, hx0, hy0, len0, red0[7][8], red0[6][8], red0[9][7], red0[10][7]} !== {2'd0, 4'd8, 4'd8, 8'd3, 4'b1100}) begin
      errors++;
      $display("FAIL reload got %h want %h", {st0, hx0, hy0, len0, red0[7][8], red0[6][8], red0[9][7], red0[10][7]}, {2'd0, 4'd8, 4'd8, 8'd3, 4'b1100});
    end
    do_reset();
    start = 1; cyc(); start = 0;
    enable = 1; direction = 1;
    apple_x = 9; apple_y = 8; cyc();
    apple_x = 0; apple_y = 0;
    direction = 2; cyc();
    direction = 0; cyc();
    direction = 3; cyc();
    enable = 0;
    vectors++;
    if ({st0, hx0, hy0, len0} !== {2'd1, 4'd8, 4'd8, 8'd4}) begin
      errors++;
      $display("FAIL tail_chase got %h want %h", {st0, hx0, hy0, len0}, {2'd1, 4'd8, 4'd8, 8'd4});
    end
  endtask

  task automatic test_cap();
    do_reset();
    start = 1; cyc(); start = 0;
    enable = 1; direction = 1;
    apple_x = 9; apple_y = 8; cyc();
    vectors++;
    if ({ate1, len1} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL cap_fill got %h want %h", {ate1, len1}, {1'b1, 3'd4});
    end
    apple_x = 10; cyc();
    enable = 0;
    vectors++;
    if ({ate1, hx1, hy1, len1, red1[6][8], red1[7][8], red1[10][8], grn1[10][8]} !== {1'b1, 4'd10, 4'd8, 3'd4, 4'b0111}) begin
      errors++;
      $display("FAIL cap_full got %h want %h", {ate1, hx1, hy1, len1, red1[6][8], red1[7][8], red1[10][8], grn1[10][8]}, {1'b1, 4'd10, 4'd8, 3'd4, 4'b0111});
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    start = 1; cyc(); start = 0;
    direction = 1; enable = 1;
    repeat (2) cyc();
    apple_x = 11; apple_y = 8;
    rst = 1;
    mst = 0;
    model_init();
    #2;
    vectors++;
    if ({st0, hx0, hy0, len0, ate0, dead0} !== {2'd0, 4'd8, 4'd8, 8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_async got %h want %h", {st0, hx0, hy0, len0, ate0, dead0}, {2'd0, 4'd8, 4'd8, 8'd3, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({ate0, hx0, red0 !== exp_red()} !== {1'b0, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_hold got ate %b hx %0d red %h want ate 0 hx 8 red %h", ate0, hx0, red0, exp_red());
    end
    @(negedge clk);
    rst = 0; enable = 0;
  endtask

  task automatic test_random();
    int dx, dy;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      start = $urandom_range(0, 7) == 0;
      enable = $urandom_range(0, 1);
      direction = 2'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        dx = (mhd == 1) - (mhd == 0);
        dy = (mhd == 3) - (mhd == 2);
        apple_x = 4'((mqx[$] + dx) & 15);
        apple_y = 4'((mqy[$] + dy) & 15);
      end else begin
        apple_x = 4'($urandom);
        apple_y = 4'($urandom);
      end
      cyc();
      vectors++;
      if ({st0, hx0, hy0, len0, ate0, dead0} !== {2'(mst), 4'(mqx[$]), 4'(mqy[$]), 8'(mqx.size()), 1'(mate), mst == 2}) begin
        errors++;
        $display("FAIL rand_regs cycle %0d got %h want %h", n, {st0, hx0, hy0, len0, ate0, dead0}, {2'(mst), 4'(mqx[$]), 4'(mqy[$]), 8'(mqx.size()), 1'(mate), mst == 2});
      end
      vectors++;
      if (red0 !== exp_red()) begin
        errors++;
        $display("FAIL rand_red cycle %0d got %h want %h", n, red0, exp_red());
      end
      vectors++;
      if (grn0 !== exp_grn()) begin
        errors++;
        $display("FAIL rand_grn cycle %0d got %h want %h", n, grn0, exp_grn());
      end
    end
    enable = 0; start = 0;
  endtask

  initial begin
    test_reset();
    test_move();
    test_eat();
    test_wall();
    test_self();
    test_cap();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 16, meaning grid columns (power of two, 4..64).
REQ-002 SHALL have parameter GRID_H, default 16, meaning grid rows (power of two, 4..64).
REQ-003 SHALL have parameter MAX_LEN, default 128, meaning segment capacity (power of two, at most GRID_W*GRID_H).
REQ-004 SHALL have parameter WRAP, default 0, meaning 1 = edges wrap around and 0 = edge exit is fatal.
REQ-005 SHALL have the following ports; XW=$clog2(GRID_W), YW=$clog2(GRID_H), LW=$clog2(MAX_LEN+1).
- clk  in  1  system clock, all state on rising edge; one clock only.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  step tick, one move per high cycle while in RUN.
- start  in  1  leave IDLE (begin play), or leave DEAD (reload).
- direction  in  2  00 left (x-1), 01 right (x+1), 10 up (y-1), 11 down (y+1).
- apple_x / apple_y  in  XW / YW  current apple cell.
- head_x / head_y  out  XW / YW  registered head cell.
- snake_length  out  LW  registered segment count.
- apple_eaten  out  1  one-cycle pulse on the step the head enters the apple cell.
- dead  out  1  high in DEAD.
- state  out  2  00 IDLE, 01 RUN, 10 DEAD.
- RedPixels  out  GRID_W x GRID_H  body cells excluding head, plus apple cell, indexed [x][y].
- GrnPixels  out  GRID_W x GRID_H  head cell only.

Function
REQ-006 SHALL store segments in a MAX_LEN-deep circular buffer with head and tail pointers, wrapping modulo MAX_LEN; no whole-body shifting.
REQ-007 SHALL keep a GRID_W x GRID_H occupancy bitmap, updated per step: set the new head cell, clear the old tail cell unless growing.
REQ-008 SHALL load the initial snake on reset and on reload: head (GRID_W/2, GRID_H/2), segments (GRID_W/2-1, GRID_H/2) and (GRID_W/2-2, GRID_H/2), length 3, heading right.
REQ-009 SHALL run the FSM IDLE -> RUN on start; RUN -> DEAD on a fatal step; DEAD -> IDLE on start, with reload in that same cycle.
REQ-010 SHALL ignore enable in IDLE and DEAD; start SHALL be ignored in RUN.
REQ-011 SHALL apply direction only on an enable cycle, and a direction opposite the current heading SHALL be ignored so the current heading is kept.
REQ-012 SHALL compute the next head from head plus heading; with WRAP=1 the coordinates wrap modulo GRID_W/GRID_H, and with WRAP=0 leaving the grid is fatal.
REQ-013 SHALL define grow = next head equals (apple_x, apple_y) AND snake_length < MAX_LEN; at MAX_LEN the apple is still eaten (pulse) but length does not change.
REQ-014 SHALL treat the next head as fatal when it hits an occupied cell, except the current tail cell when grow=0, because that cell vacates on the same step.
REQ-015 SHALL, on a fatal step: enter DEAD, leave head, length, buffer and bitmap unchanged, emit no apple_eaten pulse, and freeze the pixels at pre-step values.
REQ-016 SHALL, on a non-fatal step, make the new head, length, pixels and apple_eaten visible on the cycle after the enable edge (latency 1); the pixels SHALL be consistent with head and length at every cycle.
REQ-017 SHALL, when grow=1, keep the tail and increment snake_length by 1.
REQ-018 SHALL, when grow=0, advance the tail pointer and keep snake_length unchanged.
REQ-019 SHALL drive RedPixels at the apple cell regardless of state; if the apple sits on the head, GrnPixels SHALL be set there as well.
REQ-020 SHALL give start priority over enable when both are asserted together in DEAD, which means reload.

Reset
REQ-021 SHALL, while rst is high, asynchronously force: state IDLE, the initial snake of REQ-008, head (GRID_W/2, GRID_H/2), snake_length 3, apple_eaten 0, dead 0, bitmap holding only the 3 initial cells, and pixels matching.
REQ-022 SHALL abandon any step in progress when rst is asserted mid-RUN, with no partial buffer or bitmap update.

Verification
REQ-023 Reset then no start, 5 enables -> state IDLE, head (8,8), length 3, GrnPixels[8][8]=1, RedPixels[7][8]=RedPixels[6][8]=1.
REQ-024 Start, dir 01, 3 enables -> head (11,8), length 3, RedPixels[7][8]=0, RedPixels[9][8]=RedPixels[10][8]=1; then dir 00 + enable -> head (12,8) (reversal rejected).
REQ-025 Apple at (9,8), start, dir 01, 1 enable -> apple_eaten one-cycle pulse, head (9,8), length 4, tail still (6,8).
REQ-026 WRAP=0, drive right from (8,8) -> head reaches (15,8), next enable -> dead=1, head stays (15,8); WRAP=1 same stimulus -> head (0,8), alive.
REQ-027 Grow to length 5, then up, left, down moves -> self-hit, DEAD; length 4 same moves onto the vacating tail -> alive; start in DEAD -> IDLE with initial snake restored.
REQ-028 Assert rst mid-RUN coincident with an enable -> immediate reset values of REQ-021, no apple_eaten pulse.
